irq_pend8: RTL and testbench

Eight-channel interrupt request front-end sitting directly upstream of the 8-input priority encoder. It synchronises eight asynchronous request lines and detects their rising edges. It latches those edges into a pending register, applies a programmable enable mask, and drives the encoder's data and enable inputs. It also runs a one-deep in-service handshake with the CPU: acknowledge clears the serviced pending bit and blocks new encodes until end-of-interrupt.

---
 rtl/irq_pend8_if.sv | 38 +++
 rtl/irq_pend8.sv | 122 ++++++++++++
 tb/tb_irq_pend8.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_pend8_if.sv
// irq_pend8_if
// Bundles the request, mask-write and CPU handshake signals of irq_pend8.
//   irq    [7:0]  asynchronous rising-edge interrupt request lines
//   we            mask write strobe
//   wmask  [7:0]  mask write data, 1 enables a channel
//   ack           CPU acknowledge pulse
//   ackn   [2:0]  channel being acknowledged
//   eoi           end-of-interrupt pulse
//   d      [7:0]  masked pending vector to the priority encoder
//   ena           priority encoder enable
//   mask   [7:0]  current mask register
//   busy          a channel is in service
//   isn    [2:0]  channel in service
// The master modport drives requests and CPU strobes.
// The slave modport is the irq_pend8 side.
interface irq_pend8_if;
    logic [7:0] irq;
    logic       we;
    logic [7:0] wmask;
    logic       ack;
    logic [2:0] ackn;
    logic       eoi;
    logic [7:0] d;
    logic       ena;
    logic [7:0] mask;
    logic       busy;
    logic [2:0] isn;

    modport master (
        output irq, we, wmask, ack, ackn, eoi,
        input  d, ena, mask, busy, isn
    );

    modport slave (
        input  irq, we, wmask, ack, ackn, eoi,
        output d, ena, mask, busy, isn
    );
endinterface

// File: rtl/irq_pend8.sv
// irq_pend8
// Eight-channel interrupt front-end that sits in front of an 8-input priority encoder.
// It synchronises the request lines and turns their rising edges into pending bits.
// The pending vector is masked before it reaches the encoder.
// A one-deep in-service handshake blocks new encodes between ack and eoi.
// Ports:
//   clk    system clock, rising edge
//   clrn   asynchronous active-low reset
//   bus    irq_pend8_if.slave (irq/we/wmask/ack/ackn/eoi in; d/ena/mask/busy/isn out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | encoder enabled, waiting for a valid ack
// SERV  | one channel in service, encoder disabled, waiting for eoi
module irq_pend8 (
    input  logic         clk,
    input  logic         clrn,
    irq_pend8_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SERV = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [7:0] s1_q;
    logic [7:0] s2_q;
    logic [7:0] s3_q;
    logic [7:0] rise;
    logic [7:0] pend_q;
    logic [7:0] pend_d;
    logic [7:0] mask_q;
    logic [7:0] d_w;
    logic [7:0] clr;
    logic [2:0] isn_q;
    logic [2:0] isn_d;
    logic       ack_ok;

    // s1 is the metastability stage.
    // The s2/s3 pair gives one edge per low-to-high transition.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_q <= 8'h00;
            s2_q <= 8'h00;
            s3_q <= 8'h00;
        end else begin
            s1_q <= bus.irq;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    assign d_w  = pend_q & mask_q;

    // Validity is judged on the pre-write d.
    // A mask write in the same cycle therefore cannot veto or enable this ack.
    assign ack_ok = (state_q == IDLE) && bus.ack && d_w[bus.ackn];

    assign clr = ack_ok ? (8'd1 << bus.ackn) : 8'd0;

    // A new edge wins over a clear on the same bit, so the request is not lost.
    assign pend_d = (pend_q & ~clr) | rise;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pend_q <= 8'h00;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mask_q <= 8'h00;
        end else if (bus.we) begin
            mask_q <= bus.wmask;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            isn_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            isn_q   <= isn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        isn_d   = isn_q;
        case (state_q)
            IDLE: begin
                if (ack_ok) begin
                    state_d = SERV;
                    isn_d   = bus.ackn;
                end
            end
            SERV: begin
                if (bus.eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.d    = d_w;
    assign bus.mask = mask_q;
    assign bus.ena  = (state_q == IDLE);
    assign bus.busy = (state_q == SERV);
    assign bus.isn  = isn_q;

endmodule

// File: tb/tb_irq_pend8.sv
module tb_irq_pend8;

    logic clk;
    logic clrn;
    int   vectors;
    int   miscompares;

    irq_pend8_if bus ();

    irq_pend8 dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // reset with requests high and a mask write pending
        clrn          = 1'b0;
        bus.irq       = 8'hFF;
        bus.we        = 1'b1;
        bus.wmask     = 8'hFF;
        bus.ack       = 1'b0;
        bus.ackn      = 3'd0;
        bus.eoi       = 1'b0;
        tick();
        chk("rst_d",    bus.d, 8'h00);
        chk("rst_mask", bus.mask, 8'h00);
        chk("rst_ena",  {7'd0, bus.ena}, 8'h01);
        chk("rst_busy", {7'd0, bus.busy}, 8'h00);
        chk("rst_isn",  {5'd0, bus.isn}, 8'h00);

        // release, mask write lands on E1; lines held high give one edge each
        clrn = 1'b1;
        tick();
        bus.we = 1'b0;
        chk("rel_mask_e1", bus.mask, 8'hFF);
        chk("rel_d_e1",    bus.d, 8'h00);
        tick();
        chk("rel_d_e2",    bus.d, 8'h00);
        tick();
        chk("rel_d_e3",    bus.d, 8'hFF);

        // enter service, then reset mid-service
        bus.ack  = 1'b1;
        bus.ackn = 3'd0;
        tick();
        bus.ack = 1'b0;
        chk("srv0_busy", {7'd0, bus.busy}, 8'h01);
        chk("srv0_d",    bus.d, 8'hFE);
        bus.irq = 8'h00;
        clrn    = 1'b0;
        #1;
        chk("midrst_busy", {7'd0, bus.busy}, 8'h00);
        chk("midrst_ena",  {7'd0, bus.ena}, 8'h01);
        chk("midrst_d",    bus.d, 8'h00);
        chk("midrst_mask", bus.mask, 8'h00);
        tick();
        clrn = 1'b1;
        bus.we    = 1'b1;
        bus.wmask = 8'hFF;
        tick();
        bus.we = 1'b0;
        chk("lat_mask", bus.mask, 8'hFF);

        // latency: three edges from irq to d
        bus.irq = 8'h20;
        tick();
        chk("lat_e1", bus.d, 8'h00);
        tick();
        chk("lat_e2", bus.d, 8'h00);
        tick();
        chk("lat_e3", bus.d, 8'h20);
        bus.ack  = 1'b1;
        bus.ackn = 3'd5;
        tick();
        bus.ack = 1'b0;
        chk("lat_ack_d",   bus.d, 8'h00);
        chk("lat_ack_isn", {5'd0, bus.isn}, 8'h05);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("lat_eoi_ena", {7'd0, bus.ena}, 8'h01);
        tick();
        tick();
        tick();
        chk("lat_noretrig", bus.d, 8'h00);

        // ack/eoi handshake with d=0xA0
        bus.irq = 8'h00;
        tick();
        tick();
        tick();
        bus.irq = 8'hA0;
        tick();
        tick();
        tick();
        chk("hs_d", bus.d, 8'hA0);
        bus.ack  = 1'b1;
        bus.ackn = 3'd7;
        tick();
        chk("hs_ack_d",    bus.d, 8'h20);
        chk("hs_ack_ena",  {7'd0, bus.ena}, 8'h00);
        chk("hs_ack_busy", {7'd0, bus.busy}, 8'h01);
        chk("hs_ack_isn",  {5'd0, bus.isn}, 8'h07);
        bus.ackn = 3'd5;
        tick();
        bus.ack = 1'b0;
        chk("hs_ack2_d",   bus.d, 8'h20);
        chk("hs_ack2_isn", {5'd0, bus.isn}, 8'h07);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("hs_eoi_ena",  {7'd0, bus.ena}, 8'h01);
        chk("hs_eoi_busy", {7'd0, bus.busy}, 8'h00);
        chk("hs_eoi_isn",  {5'd0, bus.isn}, 8'h07);

        // ack on a channel that is not pending is ignored
        bus.ack  = 1'b1;
        bus.ackn = 3'd3;
        tick();
        bus.ack = 1'b0;
        chk("inv_d",    bus.d, 8'h20);
        chk("inv_ena",  {7'd0, bus.ena}, 8'h01);
        chk("inv_busy", {7'd0, bus.busy}, 8'h00);
        chk("inv_isn",  {5'd0, bus.isn}, 8'h07);

        // ack and eoi together in IDLE: ack wins
        bus.ack  = 1'b1;
        bus.ackn = 3'd5;
        bus.eoi  = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        chk("ae_idle_busy", {7'd0, bus.busy}, 8'h01);
        chk("ae_idle_isn",  {5'd0, bus.isn}, 8'h05);
        chk("ae_idle_d",    bus.d, 8'h00);
        // in SERV: eoi wins
        bus.ack  = 1'b1;
        bus.ackn = 3'd7;
        bus.eoi  = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        chk("ae_serv_busy", {7'd0, bus.busy}, 8'h00);
        chk("ae_serv_isn",  {5'd0, bus.isn}, 8'h05);

        // mask gating, pending retained while masked
        bus.irq   = 8'h00;
        bus.we    = 1'b1;
        bus.wmask = 8'h00;
        tick();
        bus.we = 1'b0;
        tick();
        tick();
        bus.irq = 8'h08;
        tick();
        tick();
        tick();
        chk("mg_d0",   bus.d, 8'h00);
        chk("mg_ena",  {7'd0, bus.ena}, 8'h01);
        bus.we    = 1'b1;
        bus.wmask = 8'h08;
        tick();
        chk("mg_d8",   bus.d, 8'h08);
        bus.wmask = 8'h00;
        tick();
        chk("mg_dx",   bus.d, 8'h00);
        bus.wmask = 8'h08;
        tick();
        bus.we = 1'b0;
        chk("mg_keep", bus.d, 8'h08);

        // ack with a concurrent mask write uses the old mask
        bus.we    = 1'b1;
        bus.wmask = 8'h00;
        bus.ack   = 1'b1;
        bus.ackn  = 3'd3;
        tick();
        bus.we  = 1'b0;
        bus.ack = 1'b0;
        chk("mw_ack_busy", {7'd0, bus.busy}, 8'h01);
        chk("mw_ack_isn",  {5'd0, bus.isn}, 8'h03);
        chk("mw_ack_mask", bus.mask, 8'h00);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;

        // collision: new edge on bit 2 in the same cycle as ack of channel 2
        bus.we    = 1'b1;
        bus.wmask = 8'hFF;
        bus.irq   = 8'h0C;
        tick();
        bus.we = 1'b0;
        tick();
        tick();
        chk("col_pre_d", bus.d, 8'h04);
        bus.irq = 8'h08;
        tick();
        tick();
        tick();
        bus.irq = 8'h0C;
        tick();
        tick();
        bus.ack  = 1'b1;
        bus.ackn = 3'd2;
        tick();
        bus.ack = 1'b0;
        chk("col_busy", {7'd0, bus.busy}, 8'h01);
        chk("col_isn",  {5'd0, bus.isn}, 8'h02);
        chk("col_d",    bus.d, 8'h04);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("col_eoi_ena", {7'd0, bus.ena}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
